// File: rtl/lpddr2_arb_pkg.sv
// Shared types and default sizing for the LPDDR2 two-port command arbiter.
package lpddr2_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam int unsigned ADDR_W_DEF = 27;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MAX_RD_DEF = 4;

endpackage

// File: rtl/lpddr2_port_arbiter_tag_fifo.sv
// In-order tag FIFO recording which port owns each outstanding read.
module arb_tag_fifo
  import lpddr2_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_RD_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  port_id_t         push_data,
  input  logic             pop,
  output port_id_t         head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  port_id_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lpddr2_port_arbiter.sv
// Two-port arbiter onto one LPDDR2 controller command port with in-order read return.
// Define LPDDR2_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module lpddr2_port_arbiter
  import lpddr2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MAX_RD = MAX_RD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              rd_err
);

  localparam int unsigned CNT_W = $clog2(MAX_RD) + 1;

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wdata;
  port_id_t          cmd_port;
  port_id_t          last_grant;
  port_id_t          grant_port;
  logic              grant;
  logic              retire;
  logic              rd_room;
  logic              elig0, elig1;
  logic              tag_push, tag_pop, tag_empty, tag_full;
  port_id_t          tag_head;
  logic [CNT_W-1:0]  rd_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    retire     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rd_room    = (rd_count < CNT_W'(MAX_RD));
    elig0      = req0_valid && (req0_we || rd_room);
    elig1      = req1_valid && (req1_we || rd_room);
`ifdef LPDDR2_ARB_FIXED_PRIO_EN
    grant_port = elig0 ? 1'b0 : 1'b1;
`else
    if (elig0 && elig1) grant_port = ~last_grant;
    else                grant_port = elig0 ? 1'b0 : 1'b1;
`endif
    unique case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          grant      = 1'b1;
          req0_ready = (grant_port == 1'b0);
          req1_ready = (grant_port == 1'b1);
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr   <= '0;
      cmd_we     <= 1'b0;
      cmd_wdata  <= '0;
      cmd_port   <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant) begin
      cmd_addr   <= grant_port ? req1_addr  : req0_addr;
      cmd_we     <= grant_port ? req1_we    : req0_we;
      cmd_wdata  <= grant_port ? req1_wdata : req0_wdata;
      cmd_port   <= grant_port;
      last_grant <= grant_port;
    end
  end

  assign avm_read      = (state == ISSUE) && !cmd_we;
  assign avm_write     = (state == ISSUE) && cmd_we;
  assign avm_address   = cmd_addr;
  assign avm_writedata = cmd_wdata;

  assign tag_push = retire && !cmd_we && !tag_full;
  assign tag_pop  = avm_readdatavalid && !tag_empty;

  arb_tag_fifo #(.DEPTH(MAX_RD)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (cmd_port),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (rd_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Read data with no tag outstanding is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      rd_err     <= 1'b0;
    end else begin
      rsp0_valid <= tag_pop && (tag_head == 1'b0);
      rsp1_valid <= tag_pop && (tag_head == 1'b1);
      if (tag_pop && (tag_head == 1'b0)) rsp0_data <= avm_readdata;
      if (tag_pop && (tag_head == 1'b1)) rsp1_data <= avm_readdata;
      if (avm_readdatavalid && tag_empty) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Directed self-checking bench for lpddr2_port_arbiter (default parameters).
module tb_lpddr2_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req0_ready;
  logic [26:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [26:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic [26:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        rd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lpddr2_port_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .req0_valid        (req0_valid),
    .req0_we           (req0_we),
    .req0_addr         (req0_addr),
    .req0_wdata        (req0_wdata),
    .req0_ready        (req0_ready),
    .req1_valid        (req1_valid),
    .req1_we           (req1_we),
    .req1_addr         (req1_addr),
    .req1_wdata        (req1_wdata),
    .req1_ready        (req1_ready),
    .rsp0_valid        (rsp0_valid),
    .rsp0_data         (rsp0_data),
    .rsp1_valid        (rsp1_valid),
    .rsp1_data         (rsp1_data),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .rd_err            (rd_err)
  );

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if ({avm_read, avm_write} !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %b want 00", {avm_read, avm_write}); end
    checks++; if (avm_address !== 27'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", avm_address); end
    checks++; if ({rsp0_valid, rsp1_valid, rd_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {rsp0_valid, rsp1_valid, rd_err}); end
    checks++; if ({rsp0_data, rsp1_data} !== 64'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", {rsp0_data, rsp1_data}); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int r0 = 0;
    int r1 = 0;
    logic [31:0] got = '0;
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 27'h100;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL sr_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if ({avm_read, avm_write} !== 2'b10 || avm_address !== 27'h100) begin errors++; $display("FAIL sr_issue: got rd/wr %b addr %h want 10 addr 100", {avm_read, avm_write}, avm_address); end
    @(negedge clk);
    #1;
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL sr_read_one_cycle: got %b want 0", avm_read); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      avm_readdatavalid = (i == 1);
      avm_readdata = (i == 1) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (rsp1_valid) r1++;
      if (rsp0_valid) begin r0++; got = rsp0_data; end
    end
    checks++; if (r0 !== 1 || got !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rsp0: got %0d strobes data %h want 1 strobe DEADBEEF", r0, got); end
    checks++; if (r1 !== 0) begin errors++; $display("FAIL sr_rsp1_quiet: got %0d strobes want 0", r1); end
    checks++; if (rsp0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rsp0_hold: got %h want DEADBEEF", rsp0_data); end
  endtask

  task automatic test_round_robin_and_full();
    logic g [4];
    int gi = 0;
    int bad = 0;
    logic exp_g;
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 27'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 27'h20;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        if (gi < 4) g[gi] = req1_ready;
        gi++;
      end
      @(negedge clk);
    end
    checks++; if (gi !== 4) begin errors++; $display("FAIL rr_grant_count: got %0d want 4", gi); end
    for (int i = 0; i < 4 && i < gi; i++) begin
`ifdef LPDDR2_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = (i % 2 == 1);
`endif
      if (g[i] !== exp_g) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rr_grant_order: got %0d wrong grants want 0", bad); end
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL full_block_read: got %b want 00", {req0_ready, req1_ready}); end
    req1_we = 1'b1; req1_addr = 27'h55; req1_wdata = 32'h0000CAFE;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL full_write_ok: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0; req1_we = 1'b0;
    #1;
    checks++; if (avm_write !== 1'b1 || avm_address !== 27'h55 || avm_writedata !== 32'h0000CAFE) begin errors++; $display("FAIL full_write_issue: got wr %b addr %h data %h want 1 55 CAFE", avm_write, avm_address, avm_writedata); end
    @(negedge clk);
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL full_still_blocked: got %b want 0", req0_ready); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'hA1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", req0_ready); end
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hA1) begin errors++; $display("FAIL full_first_return: got v %b data %h want 1 A1", rsp0_valid, rsp0_data); end
    req0_valid = 1'b0;
  endtask

  task automatic test_waitrequest();
    int bad = 0;
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 27'h7; req0_wdata = 32'h12345678;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req0_we = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 27'h33;
    for (int i = 0; i < 6; i++) begin
      avm_waitrequest = (i < 5);
      #1;
      if (!(avm_write === 1'b1 && avm_read === 1'b0 && avm_address === 27'h7 && avm_writedata === 32'h12345678)) bad++;
      if (req0_ready || req1_ready) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr_stall_stable: got %0d bad cycles want 0", bad); end
    #1;
    checks++; if (avm_write !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL wr_retire: got wr %b rdy1 %b want 0 1", avm_write, req1_ready); end
    req1_valid = 1'b0;
  endtask

  task automatic test_interleave();
    do_reset();
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 27'hA;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL il_accept_a: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 27'hB;
    @(negedge clk);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL il_accept_b: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 27'hC;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL il_ret1: got v1 %b d1 %h v0 %b want 1 1 0", rsp1_valid, rsp1_data, rsp0_valid); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL il_accept_c: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h2;
    @(negedge clk);
    avm_readdata = 32'h3;
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h2 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL il_ret2: got v0 %b d0 %h v1 %b want 1 2 0", rsp0_valid, rsp0_data, rsp1_valid); end
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h3 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL il_ret3: got v1 %b d1 %h v0 %b want 1 3 0", rsp1_valid, rsp1_data, rsp0_valid); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL il_no_err: got %b want 0", rd_err); end
    // All three tags consumed: one more return must be treated as spurious.
    @(negedge clk);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h4;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checks++; if (rd_err !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL il_drained: got err %b v0 %b v1 %b want 1 0 0", rd_err, rsp0_valid, rsp1_valid); end
  endtask

  task automatic test_spurious();
    do_reset();
    #1;
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL sp_clear: got %b want 0", rd_err); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h77;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checks++; if (rd_err !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL sp_flag: got err %b v0 %b v1 %b want 1 0 0", rd_err, rsp0_valid, rsp1_valid); end
    @(negedge clk);
    #1;
    checks++; if (rd_err !== 1'b1 || rsp0_data !== 32'h0) begin errors++; $display("FAIL sp_sticky: got err %b d0 %h want 1 0", rd_err, rsp0_data); end
  endtask

  task automatic test_reset_mid_issue();
    // rd_err is still set from the spurious-return scenario.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 27'h44;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (avm_read !== 1'b1 || avm_address !== 27'h44) begin errors++; $display("FAIL mi_issue: got rd %b addr %h want 1 44", avm_read, avm_address); end
    rst = 1'b1;
    #1;
    checks++; if ({avm_read, avm_write, rd_err} !== 3'b000) begin errors++; $display("FAIL mi_reset: got rd/wr/err %b want 000", {avm_read, avm_write, rd_err}); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin_and_full();
    test_waitrequest();
    test_interleave();
    test_spurious();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpddr2_port_arbiter.md
# lpddr2_port_arbiter

Shares the single LPDDR2 controller command port between two requesters: port 0 (CPU memory_master path) and port 1 (DMA/video fetch). Sits between the requesters and the LPDDR2 controller's Avalon-MM-style slave. Provides per-port valid/ready command handshakes, round-robin arbitration, a registered issue stage that honours controller waitrequest, and an in-order tag FIFO that routes read data back to the owning port.

## Interface
- ADDR_W, 27, LPDDR2 word address width
- DATA_W, 32, data width
- MAX_RD, 4, max outstanding reads; power of two, ≥2
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- reqN_valid  in  1  port N (N=0,1) command valid
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- reqN_ready  out  1  command accepted this cycle (valid && ready)
- rspN_valid  out  1  one-cycle read-data strobe for port N
- rspN_data  out  DATA_W  read data, held until next strobe
- avm_address  out  ADDR_W  controller address
- avm_read  out  1  controller read command
- avm_write  out  1  controller write command
- avm_writedata  out  DATA_W  controller write data
- avm_waitrequest  in  1  controller stall
- avm_readdata  in  DATA_W  controller read data
- avm_readdatavalid  in  1  controller read data strobe
- rd_err  out  1  sticky: readdatavalid with empty tag FIFO

## Operation
- States: IDLE, ISSUE.
- IDLE: port eligible if valid && (we || rd_count < MAX_RD). No eligible port -> stay. One eligible -> grant it. Both -> grant port != last_grant. Grant: reqN_ready=1 (combinational, IDLE only), latch addr/we/wdata/port into command registers, last_grant<=N, go ISSUE.
- ISSUE: avm_read = !cmd_we, avm_write = cmd_we, address/writedata from command registers, held stable while avm_waitrequest=1. On !avm_waitrequest: command retires; if read, push cmd_port into tag FIFO; go IDLE.
- Read return: on avm_readdatavalid, pop tag FIFO head, register avm_readdata into rspP_data, pulse rspP_valid for the owning port P. Returns strictly in issue order.
- Push and pop in same cycle: both occur, rd_count unchanged.
- readdatavalid with FIFO empty: data dropped, no rsp strobe, rd_err<=1 until reset.
- Writes never consume FIFO entries; writes accepted while FIFO full.
- reqN_ready never asserted in ISSUE; a requester's valid/fields must hold until ready.
- Reset (any time, incl. mid-ISSUE or with reads outstanding): state IDLE, FIFO empty, rd_count 0, last_grant=1 (port 0 wins first tie), all outputs 0 incl. rd_err, rspN_data. In-flight controller reads are abandoned; controller shares the same reset.

## Timing
- Accept cycle T (ready high) -> avm_read/avm_write first high T+1.
- Zero-wait controller: one command per 2 cycles (IDLE/ISSUE alternate); peak 50% port utilisation, by design.
- avm_readdatavalid at cycle R -> rspP_valid/rspP_data at R+1.
- FIFO push at retirement edge visible to IDLE eligibility on next cycle; no off-by-one: exactly MAX_RD reads may be outstanding.

## Configuration
- LPDDR2_ARB_FIXED_PRIO_EN defined: port 0 always wins when both eligible; last_grant ignored (port 1 may starve).
- Undefined: round-robin as above.

## Structure
- Package lpddr2_arb_pkg: state enum (IDLE, ISSUE), port_id_t (1 bit), default ADDR_W/DATA_W/MAX_RD constants.
- Sub-module arb_tag_fifo: synchronous FIFO of port_id_t, depth MAX_RD, push/pop/count/empty/full, asynchronous reset to empty.

## Test plan
- Single read port 0 addr 0x100, zero-wait controller, readdata 0xDEADBEEF after 3 cycles -> avm_read one cycle at T+1 with address 0x100; rsp0_valid one cycle with 0xDEADBEEF, rsp1_valid never.
- Both ports hold valid reads continuously -> grants alternate 0,1,0,1 after reset; with LPDDR2_ARB_FIXED_PRIO_EN grants all port 0.
- waitrequest high 5 cycles during write addr 0x7, data 0x12345678 -> avm_write/address/writedata stable all 6 cycles, no new reqN_ready.
- Issue 4 reads (MAX_RD=4) without returns -> 5th read not readied, write still accepted; one readdatavalid -> 5th read accepted next IDLE.
- Interleaved reads port1 A, port0 B, port1 C with returns 0x1,0x2,0x3 -> rsp1 0x1, rsp0 0x2, rsp1 0x3 in order; simultaneous push/pop keeps count correct.
- Spurious readdatavalid after reset -> rd_err=1, no rsp strobe; rst asserted mid-ISSUE -> avm_read/avm_write 0 immediately, rd_err 0.
